// File: rtl/mips_issue_arbiter.sv
// mips_issue_arbiter: two-requester round-robin issue front end for a shared MIPS ALU core.
// Each requester owns a FIFO; the issue, tag and response stages are registered.
module mips_issue_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] data,
    input  logic        pop,
    output logic        ready,
    output logic        avail,
    output logic [31:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          fresh;
    logic          push;
    assign ready = cnt != (AW+1)'(DEPTH);
    assign push  = valid && ready;
    // the entry written at the last edge is not yet eligible for issue
    assign avail = cnt > (AW+1)'(fresh);
    assign head  = mem[rp];
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            fresh <= 1'b0;
        end else begin
            wp    <= push ? wp + 1'b1 : wp;
            rp    <= pop ? rp + 1'b1 : rp;
            cnt   <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            fresh <= push;
        end
    end
endmodule

module mips_issue_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CORE_LAT   = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [31:0]      a_instr,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [31:0]      b_instr,
    input  logic             hold,
    output logic             core_in_valid,
    output logic [31:0]      core_instruction,
    input  logic             core_out_valid,
    input  logic             core_fail,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_fail,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             proto_err
);
    logic              a_avail, b_avail, pop_a, pop_b, last_grant;
    logic [31:0]       a_head, b_head;
    logic [CORE_LAT:0] tag_v, tag_id;
    logic              aligned;

    mips_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .rst(rst), .valid(a_valid), .data(a_instr), .pop(pop_a),
        .ready(a_ready), .avail(a_avail), .head(a_head)
    );
    mips_issue_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .rst(rst), .valid(b_valid), .data(b_instr), .pop(pop_b),
        .ready(b_ready), .avail(b_avail), .head(b_head)
    );

    // last_grant: 0 = A, 1 = B; on a tie the other requester wins
    assign pop_a   = !hold && a_avail && (!b_avail || last_grant);
    assign pop_b   = !hold && b_avail && (!a_avail || !last_grant);
    assign aligned = tag_v[CORE_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            core_in_valid    <= 1'b0;
            core_instruction <= '0;
            last_grant       <= 1'b1;
            tag_v            <= '0;
            tag_id           <= '0;
            rsp_valid        <= 1'b0;
            rsp_id           <= 1'b0;
            rsp_fail         <= 1'b0;
            fail_cnt         <= '0;
            proto_err        <= 1'b0;
        end else begin
            core_in_valid    <= pop_a || pop_b;
            core_instruction <= pop_a ? a_head : pop_b ? b_head : '0;
            last_grant       <= (pop_a || pop_b) ? pop_b : last_grant;
            // stage 0 is loaded alongside core_in_valid, so stage CORE_LAT meets core_out_valid
            tag_v            <= {tag_v[CORE_LAT-1:0], pop_a || pop_b};
            tag_id           <= {tag_id[CORE_LAT-1:0], pop_b};
            rsp_valid        <= core_out_valid && aligned;
            rsp_id           <= tag_id[CORE_LAT];
            rsp_fail         <= core_fail && core_out_valid && aligned;
            fail_cnt         <= (rsp_valid && rsp_fail && fail_cnt != '1) ? fail_cnt + 1'b1 : fail_cnt;
            proto_err        <= proto_err || (core_out_valid != aligned);
        end
    end
endmodule

// File: tb/tb_mips_issue_arbiter.sv
// tb_mips_issue_arbiter: vector table, corner sequences and random traffic against a queue-based model.
module tb_mips_issue_arbiter;
    localparam int L = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, hold = 1'b0, inj = 1'b0;
    logic [31:0] a_instr = '0, b_instr = '0;
    logic        a_ready, b_ready, core_in_valid, core_out_valid, core_fail;
    logic [31:0] core_instruction;
    logic        rsp_valid, rsp_id, rsp_fail, proto_err;
    logic [7:0]  fail_cnt;
    logic [1:0]  cv_p, cf_p;
    int          checks = 0, errors = 0;

    mips_issue_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_instr(a_instr),
        .b_valid(b_valid), .b_ready(b_ready), .b_instr(b_instr),
        .hold(hold),
        .core_in_valid(core_in_valid), .core_instruction(core_instruction),
        .core_out_valid(core_out_valid), .core_fail(core_fail),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_fail(rsp_fail),
        .fail_cnt(fail_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // stand-in core: fixed two-cycle latency, opcode 6'b111111 fails
    always @(posedge clk) begin
        if (rst) begin
            cv_p <= '0;
            cf_p <= '0;
        end else begin
            cv_p <= {cv_p[0], core_in_valid};
            cf_p <= {cf_p[0], core_in_valid && core_instruction[31:26] == 6'h3f};
        end
    end
    assign core_out_valid = cv_p[1] | inj;
    assign core_fail      = cf_p[1] & cv_p[1];

    typedef struct { logic [31:0] instr; int t; } ent_t;
    typedef struct { int due; logic id; logic fail; } pend_t;
    ent_t  qa[$], qb[$];
    pend_t pend[$];
    int    n, m_fc;
    logic  last, m_civ, m_rv, m_rid, m_rf, m_pe;
    logic [31:0] m_ci;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (edge %0d)", nm, act, exp, n);
        end
    endtask

    task automatic step();
        logic pua, pub, ea, eb, pa, pb;
        pua = a_valid && qa.size() < 4;
        pub = b_valid && qb.size() < 4;
        if (m_rv && m_rf && m_fc < 255) m_fc++;
        ea = qa.size() > 0 && qa[0].t + 2 <= n;
        eb = qb.size() > 0 && qb[0].t + 2 <= n;
        pa = !hold && ea && (!eb || last);
        pb = !hold && eb && (!ea || !last);
        m_civ = pa || pb;
        m_ci  = '0;
        if (pa) begin
            m_ci = qa[0].instr;
            void'(qa.pop_front());
            last = 1'b0;
        end
        if (pb) begin
            m_ci = qb[0].instr;
            void'(qb.pop_front());
            last = 1'b1;
        end
        if (m_civ) pend.push_back('{n + L + 1, pb, m_ci[31:26] == 6'h3f});
        if (pua) qa.push_back('{a_instr, n});
        if (pub) qb.push_back('{b_instr, n});
        m_rv = pend.size() > 0 && pend[0].due == n;
        m_rid = 1'b0;
        m_rf  = 1'b0;
        if (m_rv) begin
            m_rid = pend[0].id;
            m_rf  = pend[0].fail;
            void'(pend.pop_front());
        end
        if (inj) m_pe = 1'b1;
        @(posedge clk);
        #1;
        n++;
        chk("a_ready", a_ready, qa.size() < 4);
        chk("b_ready", b_ready, qb.size() < 4);
        chk("core_in_valid", core_in_valid, m_civ);
        chk("core_instruction", core_instruction, m_ci);
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_rv) chk("rsp_id", rsp_id, m_rid);
        chk("rsp_fail", rsp_fail, m_rf);
        chk("fail_cnt", fail_cnt, m_fc);
        chk("proto_err", proto_err, m_pe);
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0; inj = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_civ", core_in_valid, 0);
        chk("rst_ci", core_instruction, 0);
        chk("rst_rv", rsp_valid, 0);
        chk("rst_rid", rsp_id, 0);
        chk("rst_rf", rsp_fail, 0);
        chk("rst_fc", fail_cnt, 0);
        chk("rst_pe", proto_err, 0);
        rst = 1'b0;
        qa.delete(); qb.delete(); pend.delete();
        n = 0; last = 1'b1; m_fc = 0;
        m_civ = 0; m_ci = '0; m_rv = 0; m_rid = 0; m_rf = 0; m_pe = 0;
    endtask

    typedef struct {
        bit rst; bit av; logic [31:0] ai; bit bv; logic [31:0] bi;
        bit civ; logic [31:0] ci; bit rv; bit rid;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int issued, pushed;
        bit acc, seen;
        tbl[0]  = '{1, 1, 32'h2001_0001, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 32'h2002_0002, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 32'h2003_0003, 0, 0, 1, 32'h2001_0001, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 1, 32'h2002_0002, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 32'h2003_0003, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[8]  = '{1, 1, 32'h2004_000a, 1, 32'h2006_000c, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 32'h2005_000b, 1, 32'h2007_000d, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 32'h2004_000a, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 32'h2006_000c, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 32'h2005_000b, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 32'h2007_000d, 1, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

        do_reset();
        step();
        chk("ready_after_reset", {a_ready, b_ready}, 2'b11);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rst) do_reset();
            a_valid = tbl[i].av; a_instr = tbl[i].ai;
            b_valid = tbl[i].bv; b_instr = tbl[i].bi;
            step();
            chk($sformatf("tbl%0d_civ", i), core_in_valid, tbl[i].civ);
            chk($sformatf("tbl%0d_ci", i), core_instruction, tbl[i].ci);
            chk($sformatf("tbl%0d_rv", i), rsp_valid, tbl[i].rv);
            if (tbl[i].rv) chk($sformatf("tbl%0d_rid", i), rsp_id, tbl[i].rid);
        end

        do_reset();
        hold = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_instr = 32'h2100_0000 + i;
            step();
            if (i == 3) chk("full_after_4", a_ready, 0);
        end
        chk("held_5th_not_taken", a_ready, 0);
        hold = 1'b0; issued = 0; seen = 0;
        for (int i = 0; i < 12; i++) begin
            acc = a_valid && a_ready;
            step();
            if (acc) begin
                a_valid = 1'b0;
                seen = 1'b1;
            end
            issued += int'(core_in_valid);
        end
        chk("fifth_accepted", seen, 1);
        chk("issued_after_hold", issued, 5);
        chk("ready_after_drain", a_ready, 1);

        do_reset();
        b_valid = 1'b1; b_instr = 32'hfc00_0000;
        step();
        b_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("one_fail_cnt", fail_cnt, 1);
        pushed = 0; b_valid = 1'b1;
        for (int i = 0; i < 1000 && pushed < 300; i++) begin
            b_instr = 32'hfc00_0000 | i;
            acc = b_ready;
            step();
            if (acc) pushed++;
        end
        b_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("fail_cnt_saturated", fail_cnt, 255);

        do_reset();
        inj = 1'b1;
        step();
        inj = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("proto_err_sticky", proto_err, 1);
        chk("proto_no_rsp", rsp_valid, 0);

        do_reset();
        for (int i = 0; i < 500; i++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            hold    = $urandom_range(0, 3) == 0;
            a_instr = $urandom;
            b_instr = $urandom;
            if ($urandom_range(0, 7) == 0) a_instr[31:26] = 6'h3f;
            if ($urandom_range(0, 7) == 0) b_instr[31:26] = 6'h3f;
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0; hold = 1'b0;
        for (int i = 0; i < 15; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
